taskwait_tracker: RTL and testbench
===================================

Name: taskwait_tracker

Overview:
- Consumes the two-beat task-finish notifications produced by the command-out stage on its taskwait stream, and the taskwait requests issued by accelerators.
- Keeps a small associative table of per-parent-task balances.
- Emits a single-beat wake-up to the waiting accelerator when every child counted in its taskwait request has finished.

Parameters:
MAX_ACCS, 16, number of accelerators
ACC_BITS, $clog2(MAX_ACCS), accelerator id width
PTID_WIDTH, 32, parent task id width (1..64)
TW_ENTRIES, 16, table entries
CNT_WIDTH, 32, signed balance width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
finStream_TDATA  in  64  finish notification data
finStream_TVALID  in  1  finish beat valid
finStream_TREADY  out  1  finish beat accepted
finStream_TLAST  in  1  last beat of a notification
twReqStream_TDATA  in  64  taskwait request data
twReqStream_TVALID  in  1  request beat valid
twReqStream_TREADY  out  1  request beat accepted
twReqStream_TID  in  ACC_BITS  requesting accelerator
wakeStream_TDATA  out  64  wake-up data: zero-extended ptid
wakeStream_TVALID  out  1  wake-up valid
wakeStream_TREADY  in  1  wake-up accepted
wakeStream_TID  out  ACC_BITS  destination accelerator
wakeStream_TLAST  out  1  always 1
overflow  out  1  sticky flag: table full on allocation

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - all TREADY 0, wakeStream_TVALID 0, overflow 0, all entries invalid.
  - FSM returns to IDLE even mid-message; partially read messages are discarded.
- Finish message, two beats:
  - beat1 is ignored.
  - beat2 (TLAST=1) carries ptid = TDATA[PTID_WIDTH-1:0].
  - A beat1 arriving with TLAST=1 is treated as beat2.
- Request message, two beats:
  - beat1 carries n = TDATA[31:0], the number of children created.
  - beat2 carries ptid = TDATA[PTID_WIDTH-1:0]; acc = TID latched at beat2.
- Entry fields: valid, ptid, signed bal[CNT_WIDTH], has_req, acc.
- FSM states:
  - IDLE: picks a source, with fin/req priority alternating on each grant when both are valid; otherwise takes whichever is valid.
  - RD_FIN1, RD_FIN2 / RD_REQ1, RD_REQ2: TREADY=1 only for the selected stream and only in these states; advance on TVALID.
  - LOOKUP: one cycle; parallel compare of ptid against valid entries gives hit and index; a priority encoder gives the lowest free index.
  - UPDATE: one cycle, see table update below.
  - WAKE: TVALID=1 with TDATA, TID stable until TREADY; then IDLE.
- Table update in UPDATE:
  - Finish, hit: bal+1.
  - Finish, miss: allocate, bal=+1, has_req=0.
  - Request, hit: bal-n, has_req=1, acc latched.
  - Request, miss: allocate, bal=-n, has_req=1.
  - Request with n=0 and miss: no allocation, go straight to WAKE.
  - When has_req=1 and the resulting bal=0: free the entry (same cycle), then WAKE.
  - Otherwise return to IDLE.
- Arithmetic: bal is two's complement and wraps silently; finishes may precede the request, so negative and positive balances are both legal.
- Full table on a needed allocation: message dropped, overflow set (sticky until rst), return to IDLE; no stall.
- A second request for a ptid with has_req=1: bal-=n, acc overwritten.
- Latency, counted from the accepted request beat2 at cycle T: LOOKUP at T+1, UPDATE at T+2, wakeStream_TVALID at T+3. Finish throughput is 1 message per 5 cycles minimum.

Test Plan:
- Early finishes: finish ptid=0x12 three times, then request n=3 ptid=0x12 TID=5 -> wake TDATA=0x12, TID=5, TLAST=1 at T+3; entry freed.
- Request first: request n=2 ptid=0x7 TID=1, then two finishes ptid=0x7 -> no wake after the first, wake TID=1 after the second; wakeStream_TREADY held low 4 cycles -> TVALID and data held stable.
- Zero children: request n=0 ptid=0x9 TID=3 on an empty table -> wake at T+3, no entry allocated (table stays empty).
- Table full: 16 finishes with distinct ptids, then a 17th distinct ptid -> overflow=1, message dropped; a finish to an existing ptid still updates it.
- Arbitration: fin and req valid continuously -> grants alternate fin, req, fin, req; no beat lost or reordered.
- Reset mid-message: rst after fin beat1 -> TREADY=0, table cleared, overflow=0; the next finish is parsed from beat1.

Source files
------------

// File: rtl/taskwait_tracker.sv
// rtl/taskwait_tracker.sv - per-parent-task taskwait balance tracker with wake-up generation
//
// Purpose:
//   Counts task-finish notifications and taskwait requests per parent task id
//   (ptid) in a small associative table. When every child counted by a
//   taskwait request has finished, a single-beat wake-up goes to the
//   accelerator that issued the request.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   finStream_*              two-beat finish notifications (beat2 carries ptid)
//   twReqStream_*            two-beat taskwait requests (beat1: n, beat2: ptid, TID: acc)
//   wakeStream_*             single-beat wake-up (TDATA: zero-extended ptid, TID: acc)
//   overflow                 sticky, set when an allocation finds the table full

module taskwait_tracker #(
    parameter int MAX_ACCS   = 16,
    parameter int ACC_BITS   = $clog2(MAX_ACCS),
    parameter int PTID_WIDTH = 32,
    parameter int TW_ENTRIES = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [63:0]         finStream_TDATA,
    input  logic                finStream_TVALID,
    output logic                finStream_TREADY,
    input  logic                finStream_TLAST,

    input  logic [63:0]         twReqStream_TDATA,
    input  logic                twReqStream_TVALID,
    output logic                twReqStream_TREADY,
    input  logic [ACC_BITS-1:0] twReqStream_TID,

    output logic [63:0]         wakeStream_TDATA,
    output logic                wakeStream_TVALID,
    input  logic                wakeStream_TREADY,
    output logic [ACC_BITS-1:0] wakeStream_TID,
    output logic                wakeStream_TLAST,

    output logic                overflow
);

    localparam int IDX_W = (TW_ENTRIES > 1) ? $clog2(TW_ENTRIES) : 1;
    localparam logic [CNT_WIDTH-1:0] BAL_ONE = CNT_WIDTH'(1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_FIN1 = 3'd1;
    localparam logic [2:0] S_RD_FIN2 = 3'd2;
    localparam logic [2:0] S_RD_REQ1 = 3'd3;
    localparam logic [2:0] S_RD_REQ2 = 3'd4;
    localparam logic [2:0] S_LOOKUP  = 3'd5;
    localparam logic [2:0] S_UPDATE  = 3'd6;
    localparam logic [2:0] S_WAKE    = 3'd7;

    // Control and message registers
    logic [2:0]            state_q, state_d;
    logic                  prio_req_q, prio_req_d;   // 1: request wins the next tie
    logic                  is_req_q, is_req_d;       // message being processed is a request
    logic [31:0]           n_q, n_d;
    logic [PTID_WIDTH-1:0] ptid_q, ptid_d;
    logic [ACC_BITS-1:0]   cur_acc_q, cur_acc_d;
    logic                  hit_q, hit_d;
    logic [IDX_W-1:0]      hit_idx_q, hit_idx_d;
    logic                  free_q, free_d;
    logic [IDX_W-1:0]      free_idx_q, free_idx_d;
    logic                  overflow_q, overflow_d;
    logic [ACC_BITS-1:0]   wake_acc_q, wake_acc_d;

    // Table storage
    logic                  ent_valid_q   [TW_ENTRIES];
    logic                  ent_valid_d   [TW_ENTRIES];
    logic [PTID_WIDTH-1:0] ent_ptid_q    [TW_ENTRIES];
    logic [PTID_WIDTH-1:0] ent_ptid_d    [TW_ENTRIES];
    logic [CNT_WIDTH-1:0]  ent_bal_q     [TW_ENTRIES];
    logic [CNT_WIDTH-1:0]  ent_bal_d     [TW_ENTRIES];
    logic                  ent_has_req_q [TW_ENTRIES];
    logic                  ent_has_req_d [TW_ENTRIES];
    logic [ACC_BITS-1:0]   ent_acc_q     [TW_ENTRIES];
    logic [ACC_BITS-1:0]   ent_acc_d     [TW_ENTRIES];

    // Lookup results and update temporaries
    logic                  lk_hit;
    logic [IDX_W-1:0]      lk_hit_idx;
    logic                  lk_free;
    logic [IDX_W-1:0]      lk_free_idx;
    logic [CNT_WIDTH-1:0]  n_cnt;
    logic [CNT_WIDTH-1:0]  upd_bal;
    logic                  upd_has_req;
    logic [ACC_BITS-1:0]   upd_acc;

    // Payload bits outside ptid / n carry nothing; folded here so the
    // intent of ignoring them is explicit.
    logic unused_bits;
    assign unused_bits = ^{finStream_TDATA, twReqStream_TDATA};

    // Balances are plain two's complement; n is cast to the balance width.
    assign n_cnt = CNT_WIDTH'(n_q);

    // Parallel ptid compare; ptids are unique in the table, the loop order
    // only matters for a definite encoder result.
    always_comb begin
        lk_hit     = 1'b0;
        lk_hit_idx = '0;
        for (int i = TW_ENTRIES - 1; i >= 0; i--) begin
            if (ent_valid_q[i] && (ent_ptid_q[i] == ptid_q)) begin
                lk_hit     = 1'b1;
                lk_hit_idx = IDX_W'(i);
            end
        end
    end

    // Lowest free index
    always_comb begin
        lk_free     = 1'b0;
        lk_free_idx = '0;
        for (int i = TW_ENTRIES - 1; i >= 0; i--) begin
            if (!ent_valid_q[i]) begin
                lk_free     = 1'b1;
                lk_free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        prio_req_d    = prio_req_q;
        is_req_d      = is_req_q;
        n_d           = n_q;
        ptid_d        = ptid_q;
        cur_acc_d     = cur_acc_q;
        hit_d         = hit_q;
        hit_idx_d     = hit_idx_q;
        free_d        = free_q;
        free_idx_d    = free_idx_q;
        overflow_d    = overflow_q;
        wake_acc_d    = wake_acc_q;
        ent_valid_d   = ent_valid_q;
        ent_ptid_d    = ent_ptid_q;
        ent_bal_d     = ent_bal_q;
        ent_has_req_d = ent_has_req_q;
        ent_acc_d     = ent_acc_q;
        upd_bal       = '0;
        upd_has_req   = 1'b0;
        upd_acc       = '0;

        case (state_q)
            S_IDLE: begin
                // Each grant hands the tie-break to the other source, so
                // two continuously valid streams alternate.
                if (finStream_TVALID && (!twReqStream_TVALID || !prio_req_q)) begin
                    state_d    = S_RD_FIN1;
                    is_req_d   = 1'b0;
                    prio_req_d = 1'b1;
                end else if (twReqStream_TVALID) begin
                    state_d    = S_RD_REQ1;
                    is_req_d   = 1'b1;
                    prio_req_d = 1'b0;
                end
            end

            S_RD_FIN1: begin
                if (finStream_TVALID) begin
                    if (finStream_TLAST) begin
                        // Lone last beat: take it as the ptid-carrying beat
                        ptid_d  = finStream_TDATA[PTID_WIDTH-1:0];
                        state_d = S_LOOKUP;
                    end else begin
                        state_d = S_RD_FIN2;
                    end
                end
            end

            S_RD_FIN2: begin
                if (finStream_TVALID) begin
                    ptid_d  = finStream_TDATA[PTID_WIDTH-1:0];
                    state_d = S_LOOKUP;
                end
            end

            S_RD_REQ1: begin
                if (twReqStream_TVALID) begin
                    n_d     = twReqStream_TDATA[31:0];
                    state_d = S_RD_REQ2;
                end
            end

            S_RD_REQ2: begin
                if (twReqStream_TVALID) begin
                    ptid_d    = twReqStream_TDATA[PTID_WIDTH-1:0];
                    cur_acc_d = twReqStream_TID;
                    state_d   = S_LOOKUP;
                end
            end

            S_LOOKUP: begin
                hit_d      = lk_hit;
                hit_idx_d  = lk_hit_idx;
                free_d     = lk_free;
                free_idx_d = lk_free_idx;
                state_d    = S_UPDATE;
            end

            S_UPDATE: begin
                if (hit_q) begin
                    upd_bal     = is_req_q ? (ent_bal_q[hit_idx_q] - n_cnt)
                                           : (ent_bal_q[hit_idx_q] + BAL_ONE);
                    upd_has_req = is_req_q | ent_has_req_q[hit_idx_q];
                    // A repeated request redirects the wake-up to the newest requester
                    upd_acc     = is_req_q ? cur_acc_q : ent_acc_q[hit_idx_q];
                    ent_bal_d[hit_idx_q]     = upd_bal;
                    ent_has_req_d[hit_idx_q] = upd_has_req;
                    ent_acc_d[hit_idx_q]     = upd_acc;
                    if (upd_has_req && (upd_bal == '0)) begin
                        ent_valid_d[hit_idx_q] = 1'b0;
                        wake_acc_d             = upd_acc;
                        state_d                = S_WAKE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (is_req_q && (n_cnt == '0)) begin
                    // Nothing to wait for and nothing recorded: wake immediately
                    wake_acc_d = cur_acc_q;
                    state_d    = S_WAKE;
                end else if (!free_q) begin
                    // Drop the message rather than stall either stream
                    overflow_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    ent_valid_d[free_idx_q]   = 1'b1;
                    ent_ptid_d[free_idx_q]    = ptid_q;
                    ent_bal_d[free_idx_q]     = is_req_q ? ('0 - n_cnt) : BAL_ONE;
                    ent_has_req_d[free_idx_q] = is_req_q;
                    ent_acc_d[free_idx_q]     = cur_acc_q;
                    state_d                   = S_IDLE;
                end
            end

            S_WAKE: begin
                if (wakeStream_TREADY) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            prio_req_q <= 1'b0;
            is_req_q   <= 1'b0;
            n_q        <= '0;
            ptid_q     <= '0;
            cur_acc_q  <= '0;
            hit_q      <= 1'b0;
            hit_idx_q  <= '0;
            free_q     <= 1'b0;
            free_idx_q <= '0;
            overflow_q <= 1'b0;
            wake_acc_q <= '0;
            for (int i = 0; i < TW_ENTRIES; i++) begin
                ent_valid_q[i]   <= 1'b0;
                ent_ptid_q[i]    <= '0;
                ent_bal_q[i]     <= '0;
                ent_has_req_q[i] <= 1'b0;
                ent_acc_q[i]     <= '0;
            end
        end else begin
            state_q       <= state_d;
            prio_req_q    <= prio_req_d;
            is_req_q      <= is_req_d;
            n_q           <= n_d;
            ptid_q        <= ptid_d;
            cur_acc_q     <= cur_acc_d;
            hit_q         <= hit_d;
            hit_idx_q     <= hit_idx_d;
            free_q        <= free_d;
            free_idx_q    <= free_idx_d;
            overflow_q    <= overflow_d;
            wake_acc_q    <= wake_acc_d;
            ent_valid_q   <= ent_valid_d;
            ent_ptid_q    <= ent_ptid_d;
            ent_bal_q     <= ent_bal_d;
            ent_has_req_q <= ent_has_req_d;
            ent_acc_q     <= ent_acc_d;
        end
    end

    assign finStream_TREADY   = (state_q == S_RD_FIN1) || (state_q == S_RD_FIN2);
    assign twReqStream_TREADY = (state_q == S_RD_REQ1) || (state_q == S_RD_REQ2);

    // ptid_q is untouched outside the read states, so it is stable in WAKE
    assign wakeStream_TVALID = (state_q == S_WAKE);
    assign wakeStream_TDATA  = 64'(ptid_q);
    assign wakeStream_TID    = wake_acc_q;
    assign wakeStream_TLAST  = 1'b1;

    assign overflow = overflow_q;

endmodule

// File: tb/tb_taskwait_tracker.sv
// tb/tb_taskwait_tracker.sv - self-checking bench for taskwait_tracker

module tb_taskwait_tracker;

    localparam int ACC_BITS = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [63:0]         finStream_TDATA;
    logic                finStream_TVALID;
    logic                finStream_TREADY;
    logic                finStream_TLAST;
    logic [63:0]         twReqStream_TDATA;
    logic                twReqStream_TVALID;
    logic                twReqStream_TREADY;
    logic [ACC_BITS-1:0] twReqStream_TID;
    logic [63:0]         wakeStream_TDATA;
    logic                wakeStream_TVALID;
    logic                wakeStream_TREADY;
    logic [ACC_BITS-1:0] wakeStream_TID;
    logic                wakeStream_TLAST;
    logic                overflow;

    always #5 clk = ~clk;

    taskwait_tracker dut (
        .clk                (clk),
        .rst                (rst),
        .finStream_TDATA    (finStream_TDATA),
        .finStream_TVALID   (finStream_TVALID),
        .finStream_TREADY   (finStream_TREADY),
        .finStream_TLAST    (finStream_TLAST),
        .twReqStream_TDATA  (twReqStream_TDATA),
        .twReqStream_TVALID (twReqStream_TVALID),
        .twReqStream_TREADY (twReqStream_TREADY),
        .twReqStream_TID    (twReqStream_TID),
        .wakeStream_TDATA   (wakeStream_TDATA),
        .wakeStream_TVALID  (wakeStream_TVALID),
        .wakeStream_TREADY  (wakeStream_TREADY),
        .wakeStream_TID     (wakeStream_TID),
        .wakeStream_TLAST   (wakeStream_TLAST),
        .overflow           (overflow)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  tid;
    } wake_t;

    wake_t exp_q[$];

    typedef struct {
        bit          is_req;
        bit          single;
        logic [31:0] n;
        logic [31:0] ptid;
        logic [3:0]  tid;
        bit          exp_wake;
        logic [3:0]  exp_tid;
        bit          exp_ovf;
    } vec_t;

    vec_t vecs[$];

    bit   log_grants = 1'b0;
    bit   grant_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_wake(input logic [31:0] ptid, input logic [3:0] tid);
        wake_t w;
        w.data = {32'h0, ptid};
        w.tid  = tid;
        exp_q.push_back(w);
    endtask

    // Wake scoreboard: sampled 1 time unit after the falling edge, so the
    // handshake seen here is the one taken on the following rising edge.
    always begin : wake_mon
        wake_t e;
        @(negedge clk);
        #1;
        if (!rst && wakeStream_TVALID && wakeStream_TREADY) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_wake: got ptid 0x%0h tid %0d, required no wake",
                         wakeStream_TDATA, wakeStream_TID);
            end else begin
                e = exp_q.pop_front();
                check("wake_data", wakeStream_TDATA, e.data);
                check("wake_tid", {60'h0, wakeStream_TID}, {60'h0, e.tid});
                check("wake_tlast", {63'h0, wakeStream_TLAST}, 64'h1);
            end
        end
    end

    // Grant order: each rising TREADY marks the start of one message
    always begin : grant_mon
        logic prev_f, prev_r;
        prev_f = 1'b0;
        prev_r = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (log_grants) begin
                if (finStream_TREADY && !prev_f) grant_q.push_back(1'b0);
                if (twReqStream_TREADY && !prev_r) grant_q.push_back(1'b1);
            end
            prev_f = finStream_TREADY;
            prev_r = twReqStream_TREADY;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    // Called at a falling edge; returns at the falling edge after the handshake
    task automatic fin_beat(input logic [63:0] d, input logic last);
        bit done = 1'b0;
        finStream_TDATA  = d;
        finStream_TLAST  = last;
        finStream_TVALID = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            if (finStream_TREADY) begin
                @(posedge clk);
                done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL fin_handshake: got no TREADY in 200 cycles, required handshake");
        end
    endtask

    task automatic req_beat(input logic [63:0] d, input logic [3:0] tid);
        bit done = 1'b0;
        twReqStream_TDATA  = d;
        twReqStream_TID    = tid;
        twReqStream_TVALID = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            if (twReqStream_TREADY) begin
                @(posedge clk);
                done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL req_handshake: got no TREADY in 200 cycles, required handshake");
        end
    endtask

    task automatic send_fin(input logic [31:0] ptid, input bit single);
        if (!single) fin_beat(64'hFFFF_0000_ABCD_0000, 1'b0);
        fin_beat({32'h0, ptid}, 1'b1);
        finStream_TVALID = 1'b0;
    endtask

    task automatic send_req(input logic [31:0] n, input logic [31:0] ptid, input logic [3:0] tid);
        req_beat({32'h5A5A_5A5A, n}, tid);
        req_beat({32'h0, ptid}, tid);
        twReqStream_TVALID = 1'b0;
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    task automatic check_drained(input string name);
        check(name, 64'(exp_q.size()), 64'h0);
        exp_q.delete();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    function automatic vec_t mk(input bit is_req, input bit single, input logic [31:0] n,
                                input logic [31:0] ptid, input logic [3:0] tid,
                                input bit exp_wake, input logic [3:0] exp_tid, input bit exp_ovf);
        vec_t v;
        v.is_req   = is_req;
        v.single   = single;
        v.n        = n;
        v.ptid     = ptid;
        v.tid      = tid;
        v.exp_wake = exp_wake;
        v.exp_tid  = exp_tid;
        v.exp_ovf  = exp_ovf;
        return v;
    endfunction

    initial begin : main
        // Early finishes, then the request that balances them
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 32'h12, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 3, 32'h12, 5, 1, 5, 0));
        // Request first, finishes after
        vecs.push_back(mk(1, 0, 2, 32'h7, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h7, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h7, 0, 1, 1, 0));
        // Zero children on a miss
        vecs.push_back(mk(1, 0, 0, 32'h9, 3, 1, 3, 0));
        // Second request accumulates and redirects the wake
        vecs.push_back(mk(0, 0, 0, 32'h20, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 3, 32'h20, 6, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 32'h20, 8, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h20, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h20, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h20, 0, 1, 8, 0));
        // Single-beat finish counts as a full notification
        vecs.push_back(mk(0, 1, 0, 32'h33, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 32'h33, 10, 1, 10, 0));
        // Fill the table; any leaked entry above would overflow early
        for (int i = 0; i < 16; i++) vecs.push_back(mk(0, 0, 0, 32'h100 + i, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h1FF, 0, 0, 0, 1));
        // Existing entry still updates; dropped ptid left no trace
        vecs.push_back(mk(1, 0, 2, 32'h100, 7, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h100, 0, 1, 7, 1));
        vecs.push_back(mk(1, 0, 1, 32'h1FF, 9, 0, 0, 1));

        rst                = 1'b1;
        finStream_TDATA    = '0;
        finStream_TLAST    = 1'b0;
        finStream_TVALID   = 1'b1;
        twReqStream_TDATA  = '0;
        twReqStream_TID    = '0;
        twReqStream_TVALID = 1'b1;
        wakeStream_TREADY  = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_fin_tready", {63'h0, finStream_TREADY}, 64'h0);
        check("rst_req_tready", {63'h0, twReqStream_TREADY}, 64'h0);
        check("rst_wake_tvalid", {63'h0, wakeStream_TVALID}, 64'h0);
        check("rst_overflow", {63'h0, overflow}, 64'h0);
        finStream_TVALID   = 1'b0;
        twReqStream_TVALID = 1'b0;
        rst                = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            if (vecs[i].exp_wake) push_wake(vecs[i].ptid, vecs[i].exp_tid);
            if (vecs[i].is_req) send_req(vecs[i].n, vecs[i].ptid, vecs[i].tid);
            else                send_fin(vecs[i].ptid, vecs[i].single);
            settle();
            check($sformatf("vec%0d_overflow", i), {63'h0, overflow}, {63'h0, vecs[i].exp_ovf});
            check_drained($sformatf("vec%0d_wake_pending", i));
        end

        // Reset in the middle of a finish notification
        fin_beat(64'hFFFF_0000_ABCD_0000, 1'b0);
        finStream_TVALID = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_fin_tready", {63'h0, finStream_TREADY}, 64'h0);
        check("midrst_overflow", {63'h0, overflow}, 64'h0);
        check("midrst_wake_tvalid", {63'h0, wakeStream_TVALID}, 64'h0);
        rst = 1'b0;
        @(negedge clk);
        send_fin(32'h55, 1'b0);
        push_wake(32'h55, 4'd3);
        send_req(1, 32'h55, 4'd3);
        settle();
        check_drained("midrst_wake_pending");
        // Entry 0x1FF held a pending request before reset; it must be gone
        send_fin(32'h1FF, 1'b0);
        settle();
        check_drained("midrst_table_cleared");
        check("midrst_overflow_after", {63'h0, overflow}, 64'h0);

        // Wake latency: TVALID first seen in the third cycle after beat2
        pulse_reset();
        push_wake(32'h9, 4'd3);
        req_beat({32'h0, 32'h0}, 4'd3);
        req_beat({32'h0, 32'h9}, 4'd3);
        twReqStream_TVALID = 1'b0;
        check("lat_t1_tvalid", {63'h0, wakeStream_TVALID}, 64'h0);
        @(negedge clk);
        check("lat_t2_tvalid", {63'h0, wakeStream_TVALID}, 64'h0);
        @(negedge clk);
        check("lat_t3_tvalid", {63'h0, wakeStream_TVALID}, 64'h1);
        settle();
        check_drained("lat_wake_pending");

        // Back-pressure on the wake stream
        send_fin(32'h7, 1'b0);
        settle();
        wakeStream_TREADY = 1'b0;
        push_wake(32'h7, 4'd1);
        send_req(1, 32'h7, 4'd1);
        for (int k = 0; k < 20 && !wakeStream_TVALID; k++) @(negedge clk);
        check("stall_tvalid_seen", {63'h0, wakeStream_TVALID}, 64'h1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d_tvalid", k), {63'h0, wakeStream_TVALID}, 64'h1);
            check($sformatf("stall%0d_tdata", k), wakeStream_TDATA, 64'h7);
            check($sformatf("stall%0d_tid", k), {60'h0, wakeStream_TID}, 64'h1);
        end
        wakeStream_TREADY = 1'b1;
        settle();
        check_drained("stall_wake_pending");
        check("stall_tvalid_cleared", {63'h0, wakeStream_TVALID}, 64'h0);

        // Arbitration with both streams continuously valid
        pulse_reset();
        push_wake(32'h30, 4'd2);
        push_wake(32'h31, 4'd4);
        log_grants = 1'b1;
        fork
            begin
                send_fin(32'h30, 1'b0);
                send_fin(32'h31, 1'b0);
            end
            begin
                send_req(1, 32'h30, 4'd2);
                send_req(1, 32'h31, 4'd4);
            end
        join
        settle();
        log_grants = 1'b0;
        check("arb_grant_count", 64'(grant_q.size()), 64'h4);
        if (grant_q.size() == 4) begin
            for (int k = 0; k < 4; k++)
                check($sformatf("arb_grant%0d", k), {63'h0, grant_q[k]}, {63'h0, k[0]});
        end
        check_drained("arb_wake_pending");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
